// File: rtl/alu_pkg.sv
// Shared ALU definitions: ctrl codes, sequencer state encoding, error codes.
// No logic of its own; imported by the ALU and its sequencer.
// Provides is_legal_ctrl() so both sides agree on the accepted op set.
package alu_pkg;

    localparam logic [3:0] ALU_NOP   = 4'h0;
    localparam logic [3:0] ALU_ADD   = 4'h1;
    localparam logic [3:0] ALU_SUB   = 4'h2;
    localparam logic [3:0] ALU_MUL   = 4'h4;
    localparam logic [3:0] ALU_DIV   = 4'h8;
    localparam logic [3:0] ALU_ANDI  = 4'hC;
    localparam logic [3:0] ALU_ORI   = 4'hE;
    localparam logic [3:0] ALU_ADDNF = 4'hF;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_DIV0    = 2'b01;
    localparam logic [1:0] ERR_ILLEGAL = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_EXEC,
        S_WB_MAIN,
        S_WB_R0,
        S_ERR
    } seq_state_t;

    function automatic logic is_legal_ctrl(input logic [3:0] ctrl);
        case (ctrl)
            ALU_ADD, ALU_SUB, ALU_MUL, ALU_DIV,
            ALU_ANDI, ALU_ORI, ALU_ADDNF: is_legal_ctrl = 1'b1;
            default:                      is_legal_ctrl = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu.sv
// 16-bit signed ALU: add/sub/mul/div/and/or; r0 carries MUL high word or DIV remainder.
// Latency: combinational; the sequencer holds inputs for the op's EXEC window.
// Backpressure: none; ctrl NOP (4'h0) produces zeros and no flag.
module alu
    import alu_pkg::*;
#(
    parameter int DW = 16
) (
    input  logic [3:0]    ctrl,
    input  logic [DW-1:0] in1,
    input  logic [DW-1:0] in2,
    output logic [DW-1:0] out,
    output logic [DW-1:0] r0,
    output logic          overflow_flag
);

    logic signed [DW:0]     a_ext;
    logic signed [DW:0]     b_ext;
    logic signed [DW:0]     b_div;
    logic signed [DW:0]     sum_ext;
    logic signed [DW:0]     dif_ext;
    logic signed [DW:0]     quo_ext;
    logic signed [DW-1:0]   in2_div;
    logic signed [DW-1:0]   rem;
    logic [2*DW-1:0]        prod;

    always_comb begin
        a_ext   = {in1[DW-1], in1};
        b_ext   = {in2[DW-1], in2};
        // Division by zero never reaches here from the sequencer; guard keeps sim clean.
        in2_div = (in2 == '0) ? DW'(1) : $signed(in2);
        b_div   = {in2_div[DW-1], in2_div};
        sum_ext = a_ext + b_ext;
        dif_ext = a_ext - b_ext;
        quo_ext = a_ext / b_div;
        rem     = $signed(in1) % in2_div;
        prod    = {{DW{in1[DW-1]}}, in1} * {{DW{in2[DW-1]}}, in2};

        out           = '0;
        r0            = '0;
        overflow_flag = 1'b0;
        case (ctrl)
            ALU_ADD: begin
                out           = sum_ext[DW-1:0];
                overflow_flag = sum_ext[DW] ^ sum_ext[DW-1];
            end
            ALU_SUB: begin
                out           = dif_ext[DW-1:0];
                overflow_flag = dif_ext[DW] ^ dif_ext[DW-1];
            end
            ALU_MUL: begin
                out           = prod[DW-1:0];
                r0            = prod[2*DW-1:DW];
                overflow_flag = !((&prod[2*DW-1:DW-1]) || !(|prod[2*DW-1:DW-1]));
            end
            ALU_DIV: begin
                out           = quo_ext[DW-1:0];
                r0            = rem;
                overflow_flag = quo_ext[DW] ^ quo_ext[DW-1];
            end
            ALU_ANDI:  out = in1 & in2;
            ALU_ORI:   out = in1 | in2;
            ALU_ADDNF: out = sum_ext[DW-1:0];
            default: ;
        endcase
    end

endmodule

// File: rtl/alu_seq_ctrl.sv
// Multi-cycle sequencer: one op at a time into the ALU, then 1-2 register-file writeback beats.
// Latency: writeback beat sampled LAT+1 edges after accept (LAT=MUL_LAT/DIV_LAT/1).
// Backpressure: req_ready only in IDLE; wb beats held stable until wb_ready.
module alu_seq_ctrl
    import alu_pkg::*;
#(
    parameter int DW      = 16,
    parameter int AW      = 4,
    parameter int MUL_LAT = 2,
    parameter int DIV_LAT = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [3:0]    req_ctrl,
    input  logic [DW-1:0] req_a,
    input  logic [DW-1:0] req_b,
    input  logic [AW-1:0] req_rd,
    output logic          wb_valid,
    input  logic          wb_ready,
    output logic [AW-1:0] wb_addr,
    output logic [DW-1:0] wb_data,
    output logic          wb_ovf,
    output logic          err_valid,
    output logic [1:0]    err_code,
    output logic          ovf_sticky,
    input  logic          clr_status,
    output logic          busy
);

    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CW      = $clog2(MAX_LAT + 1);

    seq_state_t    state, state_nxt;
    logic [CW-1:0] cnt, cnt_init;
    logic [3:0]    op_ctrl;
    logic [DW-1:0] op_a, op_b;
    logic [AW-1:0] op_rd;
    logic [DW-1:0] res_out, res_r0;
    logic          res_ovf;

    logic [3:0]    alu_ctrl;
    logic [DW-1:0] alu_out, alu_r0;
    logic          alu_ovf;

    logic accept, req_div0, req_illegal, capture, two_beat;

    assign accept      = req_valid && (state == S_IDLE);
    assign req_div0    = (req_ctrl == ALU_DIV) && (req_b == '0);
    assign req_illegal = !is_legal_ctrl(req_ctrl);
    assign capture     = (state == S_EXEC) && (cnt == CW'(1));
    assign two_beat    = (op_ctrl == ALU_MUL) || (op_ctrl == ALU_DIV);
    // Outside EXEC the ALU sees NOP, so a rejected DIV-by-zero is never presented.
    assign alu_ctrl    = (state == S_EXEC) ? op_ctrl : ALU_NOP;

    always_comb begin
        case (req_ctrl)
            ALU_MUL: cnt_init = CW'(MUL_LAT);
            ALU_DIV: cnt_init = CW'(DIV_LAT);
            default: cnt_init = CW'(1);
        endcase
    end

    alu #(.DW(DW)) u_alu (
        .ctrl          (alu_ctrl),
        .in1           (op_a),
        .in2           (op_b),
        .out           (alu_out),
        .r0            (alu_r0),
        .overflow_flag (alu_ovf)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        busy      = 1'b1;
        wb_valid  = 1'b0;
        wb_addr   = '0;
        wb_data   = '0;
        wb_ovf    = 1'b0;
        err_valid = 1'b0;
        case (state)
            S_IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
                if (accept) state_nxt = (req_div0 || req_illegal) ? S_ERR : S_EXEC;
            end
            S_EXEC: if (cnt == CW'(1)) state_nxt = S_WB_MAIN;
            S_WB_MAIN: begin
                wb_valid = 1'b1;
                wb_addr  = op_rd;
                wb_data  = res_out;
                wb_ovf   = res_ovf;
                if (wb_ready) state_nxt = two_beat ? S_WB_R0 : S_IDLE;
            end
            S_WB_R0: begin
                wb_valid = 1'b1;
                wb_data  = res_r0;
                if (wb_ready) state_nxt = S_IDLE;
            end
            S_ERR: begin
                err_valid = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            op_ctrl    <= ALU_NOP;
            op_a       <= '0;
            op_b       <= '0;
            op_rd      <= '0;
            res_out    <= '0;
            res_r0     <= '0;
            res_ovf    <= 1'b0;
            err_code   <= ERR_NONE;
            ovf_sticky <= 1'b0;
        end else begin
            if (accept) begin
                op_ctrl <= req_ctrl;
                op_a    <= req_a;
                op_b    <= req_b;
                op_rd   <= req_rd;
                cnt     <= cnt_init;
            end else if (state == S_EXEC) begin
                cnt <= cnt - CW'(1);
            end
            if (capture) begin
                res_out <= alu_out;
                res_r0  <= alu_r0;
                res_ovf <= alu_ovf;
            end
            // A new error or a fresh overflow takes priority over a same-cycle clear.
            if (accept && req_illegal)   err_code <= ERR_ILLEGAL;
            else if (accept && req_div0) err_code <= ERR_DIV0;
            else if (clr_status)         err_code <= ERR_NONE;
            if (capture && alu_ovf)      ovf_sticky <= 1'b1;
            else if (clr_status)         ovf_sticky <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench for alu_seq_ctrl with a queue-based writeback scoreboard.
module tb_alu_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_ctrl;
    logic [15:0] req_a, req_b;
    logic [3:0]  req_rd;
    logic        wb_valid, wb_ready;
    logic [3:0]  wb_addr;
    logic [15:0] wb_data;
    logic        wb_ovf, err_valid;
    logic [1:0]  err_code;
    logic        ovf_sticky, clr_status, busy;

    typedef struct {
        logic [3:0]  addr;
        logic [15:0] data;
        logic        ovf;
        bit          chk_ovf;
        int          lat;
    } beat_t;

    beat_t exp_q[$];
    int    n_cmp = 0;
    int    n_bad = 0;
    int    cyc = 0;
    int    acc_cyc = 0;
    bit    seen = 0;

    alu_seq_ctrl #(.DW(16), .AW(4), .MUL_LAT(2), .DIV_LAT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_ctrl(req_ctrl),
        .req_a(req_a), .req_b(req_b), .req_rd(req_rd),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_addr(wb_addr),
        .wb_data(wb_data), .wb_ovf(wb_ovf),
        .err_valid(err_valid), .err_code(err_code), .ovf_sticky(ovf_sticky),
        .clr_status(clr_status), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input logic [3:0] addr, input logic [15:0] data,
                        input logic ovf, input bit chk_ovf, input int lat);
        beat_t b;
        b.addr = addr; b.data = data; b.ovf = ovf; b.chk_ovf = chk_ovf; b.lat = lat;
        exp_q.push_back(b);
    endtask

    // Monitor: every cycle a beat is presented it must match the queue head (also proves stability).
    always @(negedge clk) begin
        if (rst_n && wb_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_wb_beat", {28'h0, wb_addr}, 32'hFFFF_FFFF);
            end else begin
                if (!seen) begin
                    seen = 1;
                    if (exp_q[0].lat != 0) check("wb_latency", cyc + 1 - acc_cyc, exp_q[0].lat);
                end
                check("wb_addr", {28'h0, wb_addr}, {28'h0, exp_q[0].addr});
                check("wb_data", {16'h0, wb_data}, {16'h0, exp_q[0].data});
                if (exp_q[0].chk_ovf) check("wb_ovf", {31'h0, wb_ovf}, {31'h0, exp_q[0].ovf});
                if (wb_ready) begin
                    void'(exp_q.pop_front());
                    seen = 0;
                end
            end
        end
    end

    task automatic issue(input logic [3:0] c, input logic [15:0] a, input logic [15:0] b,
                         input logic [3:0] rd);
        int w = 0;
        while (!req_ready && w < 50) begin
            @(posedge clk); #1; w++;
        end
        if (!req_ready) check("issue_ready_timeout", 32'h0, 32'h1);
        req_valid = 1'b1; req_ctrl = c; req_a = a; req_b = b; req_rd = rd;
        @(posedge clk); #1;
        acc_cyc   = cyc;
        req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int w = 0;
        while ((!req_ready || exp_q.size() != 0) && w < 60) begin
            @(posedge clk); #1; w++;
        end
        check("idle_req_ready", {31'h0, req_ready}, 32'h1);
        check("idle_queue_empty", exp_q.size(), 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_ctrl = 4'h0; req_a = '0; req_b = '0;
        req_rd = '0; wb_ready = 1'b1; clr_status = 1'b0;
        #12;
        check("rst_req_ready", {31'h0, req_ready}, 32'h1);
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_wb_valid", {31'h0, wb_valid}, 32'h0);
        check("rst_err_valid", {31'h0, err_valid}, 32'h0);
        check("rst_err_code", {30'h0, err_code}, 32'h0);
        check("rst_ovf_sticky", {31'h0, ovf_sticky}, 32'h0);
        @(posedge clk); #1; rst_n = 1'b1;
        @(posedge clk); #1;

        // ADD overflow: 7FFF + 1
        push(4'd3, 16'h8000, 1'b1, 1, 2);
        issue(4'h1, 16'h7FFF, 16'h0001, 4'd3);
        wait_idle();
        check("add_ovf_sticky", {31'h0, ovf_sticky}, 32'h1);

        clr_status = 1'b1; @(posedge clk); #1; clr_status = 1'b0;
        check("clr_ovf_sticky", {31'h0, ovf_sticky}, 32'h0);

        // MUL 0x0100 * 0x0100 = 0x0001_0000
        push(4'd5, 16'h0000, 1'b0, 0, 3);
        push(4'd0, 16'h0001, 1'b0, 1, 0);
        issue(4'h4, 16'h0100, 16'h0100, 4'd5);
        wait_idle();

        // DIV 7 / 2 = 3 rem 1
        push(4'd6, 16'h0003, 1'b0, 1, 5);
        push(4'd0, 16'h0001, 1'b0, 1, 0);
        issue(4'h8, 16'h0007, 16'h0002, 4'd6);
        wait_idle();

        // DIV -7 / 2 = -3 rem -1 (truncating)
        push(4'd9, 16'hFFFD, 1'b0, 1, 5);
        push(4'd0, 16'hFFFF, 1'b0, 1, 0);
        issue(4'h8, 16'hFFF9, 16'h0002, 4'd9);
        wait_idle();

        // SUB 8000 - 1 overflows to 7FFF
        push(4'd7, 16'h7FFF, 1'b1, 1, 2);
        issue(4'h2, 16'h8000, 16'h0001, 4'd7);
        wait_idle();

        // AND, and ADD without flag on a wrapping sum
        push(4'd1, 16'h00F0, 1'b0, 1, 2);
        issue(4'hC, 16'hF0F0, 16'h0FF0, 4'd1);
        wait_idle();
        push(4'd4, 16'h8000, 1'b0, 1, 2);
        issue(4'hF, 16'h7FFF, 16'h0001, 4'd4);
        wait_idle();

        // Divide by zero: error pulse, no beat
        issue(4'h8, 16'h0009, 16'h0000, 4'd2);
        check("div0_err_valid", {31'h0, err_valid}, 32'h1);
        check("div0_err_code", {30'h0, err_code}, 32'h1);
        check("div0_busy", {31'h0, busy}, 32'h1);
        @(posedge clk); #1;
        check("div0_err_pulse_end", {31'h0, err_valid}, 32'h0);
        check("div0_code_held", {30'h0, err_code}, 32'h1);
        check("div0_req_ready", {31'h0, req_ready}, 32'h1);

        // Illegal ctrl 3, with clr_status in the same accept cycle: new code wins
        clr_status = 1'b1;
        issue(4'h3, 16'h0001, 16'h0001, 4'd2);
        clr_status = 1'b0;
        check("ill_err_valid", {31'h0, err_valid}, 32'h1);
        check("ill_err_code", {30'h0, err_code}, 32'h2);
        @(posedge clk); #1;
        check("ill_err_pulse_end", {31'h0, err_valid}, 32'h0);
        clr_status = 1'b1; @(posedge clk); #1; clr_status = 1'b0;
        check("clr_err_code", {30'h0, err_code}, 32'h0);

        // Backpressure: ORI held while wb_ready low for 3 cycles
        wb_ready = 1'b0;
        push(4'd8, 16'h00FF, 1'b0, 1, 2);
        issue(4'hE, 16'h00F0, 16'h000F, 4'd8);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("bp_wb_valid", {31'h0, wb_valid}, 32'h1);
            check("bp_req_ready", {31'h0, req_ready}, 32'h0);
        end
        wb_ready = 1'b1;
        wait_idle();

        // Reset during DIV EXEC cycle 2: op discarded
        issue(4'h8, 16'h0014, 16'h0003, 4'd6);
        @(posedge clk); #1;
        rst_n = 1'b0; #1;
        check("mid_rst_busy", {31'h0, busy}, 32'h0);
        check("mid_rst_req_ready", {31'h0, req_ready}, 32'h1);
        check("mid_rst_wb_valid", {31'h0, wb_valid}, 32'h0);
        @(posedge clk); #1; rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
        end
        check("post_rst_err_valid", {31'h0, err_valid}, 32'h0);

        push(4'd2, 16'h0002, 1'b0, 1, 2);
        issue(4'h1, 16'h0001, 16'h0001, 4'd2);
        wait_idle();
        check("final_ovf_sticky", {31'h0, ovf_sticky}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
